// File: rtl/lcd_defs.sv
// Shared constants, instruction decode masks and nibble-FSM states for the LCD receiver.
package lcd_defs;

    // lcd_control bit positions
    localparam int unsigned RS_BIT = 2;
    localparam int unsigned RW_BIT = 1;
    localparam int unsigned E_BIT  = 0;

    // Instruction opcodes as mask/value pairs
    localparam logic [7:0] CLEAR          = 8'h01;
    localparam logic [7:0] HOME_MASK      = 8'hFE;
    localparam logic [7:0] HOME_VAL       = 8'h02;
    localparam logic [7:0] ENTRY_MASK     = 8'hFC;
    localparam logic [7:0] ENTRY_VAL      = 8'h04;
    localparam logic [7:0] FUNC_SET_MASK  = 8'hE0;
    localparam logic [7:0] FUNC_SET_VAL   = 8'h20;
    localparam logic [7:0] SET_DDRAM_MASK = 8'h80;
    localparam logic [7:0] SET_DDRAM_VAL  = 8'h80;

    localparam int unsigned FUNC_DL_BIT  = 4;
    localparam int unsigned ENTRY_ID_BIT = 1;

    // Nibble that switches an 8-bit-mode bus into 4-bit mode
    localparam logic [3:0] NIB_FUNC4 = 4'h2;

    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        StMode8 = 2'd0,
        StHigh  = 2'd1,
        StLow   = 2'd2
    } nib_state_e;

    function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (b & mask) == val;
    endfunction

endpackage

// File: rtl/lcd_strobe_detect.sv
// Registers the LCD bus once and reports E falling edges as valid or too-short strobes.
module lcd_strobe_detect
    import lcd_defs::*;
#(
    parameter int unsigned E_MIN_HIGH = 2
) (
    input  logic       clk_i,
    input  logic       n_clear_i,
    input  logic [3:0] lcd_dataout_i,
    input  logic [2:0] lcd_control_i,
    output logic       strobe_valid_o,
    output logic       strobe_short_o,
    output logic       strobe_rs_o,
    output logic [3:0] strobe_nib_o
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] MinHigh = CntW'(E_MIN_HIGH);
    localparam logic [CntW-1:0] CntMax  = '1;

    logic            e_q, e_d, e_prev_q, e_prev_d;
    logic            rs_q, rs_d, rw_q, rw_d;
    logic [3:0]      nib_q, nib_d;
    logic            lat_rs_q, lat_rs_d, lat_rw_q, lat_rw_d;
    logic [3:0]      lat_nib_q, lat_nib_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            falling;

    // Next state: sample bus, hold the last E-high snapshot, count E-high cycles (saturating)
    always_comb begin
        e_d       = lcd_control_i[E_BIT];
        rs_d      = lcd_control_i[RS_BIT];
        rw_d      = lcd_control_i[RW_BIT];
        nib_d     = lcd_dataout_i;
        e_prev_d  = e_q;
        lat_rs_d  = lat_rs_q;
        lat_rw_d  = lat_rw_q;
        lat_nib_d = lat_nib_q;
        cnt_d     = '0;
        if (e_q) begin
            lat_rs_d  = rs_q;
            lat_rw_d  = rw_q;
            lat_nib_d = nib_q;
            cnt_d     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Strobe classification; cnt_q still holds the completed high width on the falling edge
    always_comb begin
        falling        = e_prev_q & ~e_q;
        strobe_short_o = falling & (cnt_q < MinHigh);
        strobe_valid_o = falling & (cnt_q >= MinHigh) & ~lat_rw_q;
        strobe_rs_o    = lat_rs_q;
        strobe_nib_o   = lat_nib_q;
    end

    // State registers with synchronous active-low clear
    always_ff @(posedge clk_i) begin
        if (!n_clear_i) begin
            e_q       <= 1'b0;
            e_prev_q  <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            nib_q     <= '0;
            lat_rs_q  <= 1'b0;
            lat_rw_q  <= 1'b0;
            lat_nib_q <= '0;
            cnt_q     <= '0;
        end else begin
            e_q       <= e_d;
            e_prev_q  <= e_prev_d;
            rs_q      <= rs_d;
            rw_q      <= rw_d;
            nib_q     <= nib_d;
            lat_rs_q  <= lat_rs_d;
            lat_rw_q  <= lat_rw_d;
            lat_nib_q <= lat_nib_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_nibble_receiver.sv
// Display end of a 4-bit character-LCD bus: byte reassembly, instruction subset, 2-row buffer.
module lcd_nibble_receiver
    import lcd_defs::*;
#(
    parameter int unsigned E_MIN_HIGH = 2,
    parameter int unsigned COLS       = 16
) (
    input  logic                          clk,
    input  logic                          nClear,
    input  logic [3:0]                    lcd_dataout,
    input  logic [2:0]                    lcd_control,
    output logic                          byte_valid,
    output logic                          byte_rs,
    output logic [7:0]                    byte_data,
    output logic                          four_bit_mode,
    output logic                          busy,
    output logic [6:0]                    ddram_addr,
    input  logic [$clog2(2*COLS)-1:0]     rd_idx,
    output logic [7:0]                    rd_char,
    output logic                          proto_err
);

    localparam int unsigned Depth = 2 * COLS;
    localparam int unsigned IdxW  = $clog2(Depth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Depth - 1);

    logic            strobe_valid, strobe_short, strobe_rs;
    logic [3:0]      strobe_nib;

    nib_state_e      state_q, state_d;
    logic [3:0]      hi_nib_q, hi_nib_d;
    logic            hi_rs_q, hi_rs_d;
    logic            four_bit_q, four_bit_d;
    logic            inc_q, inc_d;
    logic [6:0]      addr_q, addr_d;
    logic            busy_q, busy_d;
    logic [IdxW-1:0] fill_idx_q, fill_idx_d;
    logic            proto_err_q, proto_err_d;
    logic            byte_valid_q, byte_valid_d;
    logic            byte_rs_q, byte_rs_d;
    logic [7:0]      byte_data_q, byte_data_d;

    logic            accept, acc_rs;
    logic [7:0]      acc_byte;
    logic            wr_en;
    logic [IdxW-1:0] wr_idx;
    logic [7:0]      wr_data;

    logic [7:0]      buf_q [Depth];

    lcd_strobe_detect #(
        .E_MIN_HIGH (E_MIN_HIGH)
    ) u_strobe (
        .clk_i          (clk),
        .n_clear_i      (nClear),
        .lcd_dataout_i  (lcd_dataout),
        .lcd_control_i  (lcd_control),
        .strobe_valid_o (strobe_valid),
        .strobe_short_o (strobe_short),
        .strobe_rs_o    (strobe_rs),
        .strobe_nib_o   (strobe_nib)
    );

    // Next state: clear fill, nibble FSM, byte acceptance and instruction/data execution
    always_comb begin
        state_d      = state_q;
        hi_nib_d     = hi_nib_q;
        hi_rs_d      = hi_rs_q;
        four_bit_d   = four_bit_q;
        inc_d        = inc_q;
        addr_d       = addr_q;
        busy_d       = busy_q;
        fill_idx_d   = fill_idx_q;
        proto_err_d  = proto_err_q;
        byte_valid_d = 1'b0;
        byte_rs_d    = byte_rs_q;
        byte_data_d  = byte_data_q;
        accept       = 1'b0;
        acc_rs       = 1'b0;
        acc_byte     = '0;
        wr_en        = 1'b0;
        wr_idx       = '0;
        wr_data      = '0;

        if (busy_q) begin
            wr_en   = 1'b1;
            wr_idx  = fill_idx_q;
            wr_data = SPACE;
            if (fill_idx_q == LastIdx) begin
                busy_d     = 1'b0;
                fill_idx_d = '0;
                addr_d     = '0;
                inc_d      = 1'b1;
            end else begin
                fill_idx_d = fill_idx_q + 1'b1;
            end
        end

        if (strobe_short) begin
            proto_err_d = 1'b1;
        end

        if (strobe_valid) begin
            unique case (state_q)
                StMode8: begin
                    accept   = 1'b1;
                    acc_rs   = strobe_rs;
                    acc_byte = {strobe_nib, 4'h0};
                    if (!strobe_rs && strobe_nib == NIB_FUNC4) begin
                        four_bit_d = 1'b1;
                        state_d    = StHigh;
                    end
                end
                StHigh: begin
                    hi_nib_d = strobe_nib;
                    hi_rs_d  = strobe_rs;
                    state_d  = StLow;
                end
                StLow: begin
                    state_d = StHigh;
                    if (strobe_rs != hi_rs_q) begin
                        proto_err_d = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        acc_rs   = strobe_rs;
                        acc_byte = {hi_nib_q, strobe_nib};
                    end
                end
                default: state_d = StMode8;
            endcase
        end

        if (accept) begin
            byte_valid_d = 1'b1;
            byte_rs_d    = acc_rs;
            byte_data_d  = acc_byte;
            if (busy_q) begin
                // Bytes arriving during the fill are reported but never executed
                proto_err_d = 1'b1;
            end else if (acc_rs) begin
                if (addr_q[5:4] == 2'b00) begin
                    wr_en   = 1'b1;
                    wr_idx  = addr_q[6] ? IdxW'(COLS) + IdxW'(addr_q[3:0]) : IdxW'(addr_q[3:0]);
                    wr_data = acc_byte;
                end
                addr_d = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
            end else if (op_match(acc_byte, SET_DDRAM_MASK, SET_DDRAM_VAL)) begin
                addr_d = acc_byte[6:0];
            end else if (op_match(acc_byte, FUNC_SET_MASK, FUNC_SET_VAL)) begin
                if (acc_byte[FUNC_DL_BIT]) begin
                    four_bit_d = 1'b0;
                    state_d    = StMode8;
                end else begin
                    four_bit_d = 1'b1;
                    state_d    = StHigh;
                end
            end else if (op_match(acc_byte, ENTRY_MASK, ENTRY_VAL)) begin
                inc_d = acc_byte[ENTRY_ID_BIT];
            end else if (op_match(acc_byte, HOME_MASK, HOME_VAL)) begin
                addr_d = '0;
            end else if (acc_byte == CLEAR) begin
                busy_d     = 1'b1;
                fill_idx_d = '0;
            end
        end
    end

    // Control/status registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!nClear) begin
            state_q      <= StMode8;
            hi_nib_q     <= '0;
            hi_rs_q      <= 1'b0;
            four_bit_q   <= 1'b0;
            inc_q        <= 1'b1;
            addr_q       <= '0;
            busy_q       <= 1'b0;
            fill_idx_q   <= '0;
            proto_err_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            hi_nib_q     <= hi_nib_d;
            hi_rs_q      <= hi_rs_d;
            four_bit_q   <= four_bit_d;
            inc_q        <= inc_d;
            addr_q       <= addr_d;
            busy_q       <= busy_d;
            fill_idx_q   <= fill_idx_d;
            proto_err_q  <= proto_err_d;
            byte_valid_q <= byte_valid_d;
            byte_rs_q    <= byte_rs_d;
            byte_data_q  <= byte_data_d;
        end
    end

    // Character buffer keeps its contents through reset; writes are suppressed while in reset
    always_ff @(posedge clk) begin
        if (nClear && wr_en) begin
            buf_q[wr_idx] <= wr_data;
        end
    end

    // Output mapping and combinational buffer read
    always_comb begin
        byte_valid    = byte_valid_q;
        byte_rs       = byte_rs_q;
        byte_data     = byte_data_q;
        four_bit_mode = four_bit_q;
        busy          = busy_q;
        ddram_addr    = addr_q;
        proto_err     = proto_err_q;
        rd_char       = buf_q[rd_idx];
    end

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Directed self-checking bench for lcd_nibble_receiver.
module tb_lcd_nibble_receiver;

    logic       clk = 1'b0;
    logic       nClear;
    logic [3:0] lcd_dataout;
    logic [2:0] lcd_control;
    logic       byte_valid, byte_rs, four_bit_mode, busy, proto_err;
    logic [7:0] byte_data, rd_char;
    logic [6:0] ddram_addr;
    logic [4:0] rd_idx;

    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;
    logic [8:0] bv_log [$];

    always #5 clk = ~clk;

    lcd_nibble_receiver dut (
        .clk           (clk),
        .nClear        (nClear),
        .lcd_dataout   (lcd_dataout),
        .lcd_control   (lcd_control),
        .byte_valid    (byte_valid),
        .byte_rs       (byte_rs),
        .byte_data     (byte_data),
        .four_bit_mode (four_bit_mode),
        .busy          (busy),
        .ddram_addr    (ddram_addr),
        .rd_idx        (rd_idx),
        .rd_char       (rd_char),
        .proto_err     (proto_err)
    );

    // Log accepted bytes and count busy cycles, sampled mid-cycle
    always @(negedge clk) begin
        if (byte_valid === 1'b1) bv_log.push_back({byte_rs, byte_data});
        if (busy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic rs, input logic rw, input logic [3:0] nib, input int hi);
        lcd_dataout = nib;
        lcd_control = {rs, rw, 1'b0};
        tick();
        lcd_control[0] = 1'b1;
        repeat (hi) tick();
        lcd_control[0] = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int hi);
        send_nib(rs, 1'b0, b[7:4], hi);
        send_nib(rs, 1'b0, b[3:0], hi);
    endtask

    task automatic do_reset();
        nClear      = 1'b0;
        lcd_control = 3'b000;
        lcd_dataout = 4'h0;
        repeat (2) tick();
        nClear = 1'b1;
        tick();
    endtask

    task automatic init4();
        send_nib(1'b0, 1'b0, 4'h3, 3);
        send_nib(1'b0, 1'b0, 4'h3, 3);
        send_nib(1'b0, 1'b0, 4'h3, 3);
        check("init_8bit_still", 32'(four_bit_mode), 32'd0);
        send_nib(1'b0, 1'b0, 4'h2, 3);
        check("init_4bit", 32'(four_bit_mode), 32'd1);
    endtask

    task automatic wait_not_busy(input string tag);
        int t;
        t = 0;
        while (busy === 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check(tag, 32'(t < 200), 32'd1);
    endtask

    initial begin
        int t;
        rd_idx = '0;
        do_reset();
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_rs", 32'(byte_rs), 32'd0);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_four_bit", 32'(four_bit_mode), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(ddram_addr), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);

        // Power-on 8-bit init sequence ending in the switch to 4-bit mode
        bv_log.delete();
        init4();
        check("init_proto_err", 32'(proto_err), 32'd0);
        check("init_bv_count", 32'(bv_log.size()), 32'd4);
        check("init_bv0", 32'(bv_log[0]), 32'h030);
        check("init_bv3", 32'(bv_log[3]), 32'h020);

        // Clear display
        busy_cnt = 0;
        send_byte(1'b0, 8'h01, 3);
        wait_not_busy("clr_timeout");
        check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
        check("clr_addr", 32'(ddram_addr), 32'd0);
        check("clr_bv", 32'(bv_log[bv_log.size()-1]), 32'h001);
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            #1;
            check($sformatf("clr_rd%0d", i), 32'(rd_char), 32'h20);
        end

        // Row 1, col 3, write 'A'
        send_byte(1'b0, 8'hC3, 3);
        send_byte(1'b1, 8'h41, 3);
        rd_idx = 5'd19;
        #1;
        check("a_rd19", 32'(rd_char), 32'h41);
        check("a_addr", 32'(ddram_addr), 32'h44);
        check("a_bv_count", 32'(bv_log.size()), 32'd7);
        check("a_bv_instr", 32'(bv_log[5]), 32'h0C3);
        check("a_bv_data", 32'(bv_log[6]), 32'h141);

        // A read strobe is ignored entirely
        send_nib(1'b0, 1'b1, 4'h0, 3);
        check("rw_bv_count", 32'(bv_log.size()), 32'd7);
        check("rw_proto_err", 32'(proto_err), 32'd0);

        // Decrement mode, minimum-width strobes
        send_byte(1'b0, 8'h04, 2);
        send_byte(1'b0, 8'h85, 2);
        send_byte(1'b1, 8'h42, 2);
        send_byte(1'b1, 8'h43, 2);
        rd_idx = 5'd5;
        #1;
        check("dec_rd5", 32'(rd_char), 32'h42);
        rd_idx = 5'd4;
        #1;
        check("dec_rd4", 32'(rd_char), 32'h43);
        check("dec_addr", 32'(ddram_addr), 32'h03);
        check("dec_proto_err", 32'(proto_err), 32'd0);

        // Too-short strobe
        send_nib(1'b1, 1'b0, 4'h7, 1);
        check("short_proto_err", 32'(proto_err), 32'd1);
        check("short_bv_count", 32'(bv_log.size()), 32'd11);
        check("short_addr", 32'(ddram_addr), 32'h03);
        rd_idx = 5'd4;
        #1;
        check("short_rd4", 32'(rd_char), 32'h43);
        repeat (5) tick();
        check("short_sticky", 32'(proto_err), 32'd1);

        // Reset in the middle of a clear
        busy_cnt = 0;
        send_byte(1'b0, 8'h01, 3);
        t = 0;
        while (busy_cnt < 10 && t < 200) begin
            tick();
            t++;
        end
        check("mid_wait", 32'(t < 200), 32'd1);
        nClear = 1'b0;
        tick();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_four_bit", 32'(four_bit_mode), 32'd0);
        check("mid_proto_err", 32'(proto_err), 32'd0);
        check("mid_addr", 32'(ddram_addr), 32'd0);
        check("mid_byte_valid", 32'(byte_valid), 32'd0);
        check("mid_byte_data", 32'(byte_data), 32'd0);
        nClear = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            rd_idx = 5'(i);
            #1;
            check($sformatf("mid_rd%0d", i), 32'(rd_char), 32'h20);
        end
        rd_idx = 5'd19;
        #1;
        check("mid_rd19", 32'(rd_char), 32'h41);
        rd_idx = 5'd10;
        #1;
        check("mid_rd10", 32'(rd_char), 32'h20);

        // Data byte during a clear is reported but dropped
        init4();
        send_byte(1'b0, 8'h85, 3);
        send_byte(1'b0, 8'h01, 3);
        send_byte(1'b1, 8'h55, 3);
        check("busy_data_proto_err", 32'(proto_err), 32'd1);
        check("busy_data_bv", 32'(bv_log[bv_log.size()-1]), 32'h155);
        wait_not_busy("busy_data_timeout");
        rd_idx = 5'd5;
        #1;
        check("busy_data_rd5", 32'(rd_char), 32'h20);
        check("busy_data_addr", 32'(ddram_addr), 32'd0);
        check("busy_data_sticky", 32'(proto_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_nibble_receiver.md
Name: lcd_nibble_receiver

Overview:
- Synthesizable model of the display end of the 4-bit character-LCD bus driven by mcu_single_cycle (lcd_dataout[3:0], lcd_control[2:0]).
- Detects E strobes, reassembles nibbles into instruction/data bytes and tracks 8-bit/4-bit interface mode.
- Executes a core instruction subset against a 2x16 character buffer, readable by the bench or a debug path.
- Instantiated beside mcu_single_cycle in system benches as the bus responder and checker.

Parameters:
- E_MIN_HIGH, 2, minimum consecutive clk cycles E must be high for a strobe to count.
- COLS, 16, characters per row; the buffer holds 2*COLS entries.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nClear  input  1  synchronous active-low reset.
- lcd_dataout  input  4  bus nibble DB7..DB4 from the MCU.
- lcd_control  input  3  bit2 = RS, bit1 = RW, bit0 = E.
- byte_valid  output  1  one-cycle pulse when a complete byte is accepted.
- byte_rs  output  1  RS of the accepted byte (1 = data, 0 = instruction).
- byte_data  output  8  the accepted byte.
- four_bit_mode  output  1  interface is in 4-bit mode.
- busy  output  1  clear-display fill in progress.
- ddram_addr  output  7  current address counter.
- rd_idx  input  5  buffer read index: row*16 + col.
- rd_char  output  8  buffer contents at rd_idx; combinational read.
- proto_err  output  1  sticky protocol-error flag; cleared only by reset.

Behaviour:
- Reset (nClear=0 at a clk edge):
  - All outputs 0 and four_bit_mode=0.
  - Nibble FSM goes to MODE8, address counter to 0, increment mode to 1.
  - Buffer contents are not cleared.
- Strobe detection:
  - E, RS, RW and the nibble are registered once.
  - A strobe is a registered E falling edge (prev=1, cur=0); data and RS are taken from the last cycle E was high.
  - If the E high count is < E_MIN_HIGH, the strobe is dropped and proto_err is set.
  - Strobes with RW=1 are ignored; reads are unsupported and the bus is never driven.
- Nibble FSM states: MODE8, HIGH, LOW.
  - MODE8: each strobe forms byte {nib,4'h0} and is executed.
    - If RS=0 and nib=4'h2, set four_bit_mode=1 and go to HIGH.
  - HIGH: latch nib as the upper nibble with its RS, then go to LOW.
  - LOW: form byte {hi,nib} and go to HIGH.
    - If RS differs from the HIGH strobe's RS, drop the byte and set proto_err.
  - An accepted byte produces byte_valid one cycle after the detected falling edge.
- Instruction execution (RS=0), in priority order:
  - 1xxxxxxx: addr = byte[6:0].
  - 001xxxxx: function set; byte[4]=0 sets four_bit_mode=1 and moves the FSM to HIGH after the current byte; byte[4]=1 sets four_bit_mode=0 and moves the FSM to MODE8.
  - 000001xx: increment mode = byte[1].
  - 0000001x: addr = 0.
  - 00000001: clear; busy=1 for 2*COLS cycles, each cycle writes 8'h20 to the next buffer index 0..31; addr=0 and increment mode=1 at the end.
  - All other instructions are accepted (byte_valid) with no effect.
- Data (RS=1):
  - If addr[5:4]==2'b00, write the byte to index {addr[6], addr[3:0]}; other addresses are not stored.
  - Then addr = addr ± 1, modulo 128.
- While busy=1:
  - Any accepted byte still pulses byte_valid but is not executed, and proto_err is set.
  - Strobe detection continues.
- Simultaneous events: the clear-fill write and a data write never coincide, because data is dropped while busy.
- Reset mid-clear: busy=0 at once and the partial fill remains.

Decomposition:
- Shared package lcd_defs:
  - control bit indices RS_BIT=2, RW_BIT=1, E_BIT=0;
  - instruction opcodes/masks (CLEAR, HOME, ENTRY, FUNC_SET, SET_DDRAM);
  - FSM state encodings;
  - SPACE=8'h20.
- One sub-module, lcd_strobe_detect: input registering, E high-width counter, valid-strobe and short-pulse outputs.

Test Plan:
- Reset, then strobes of nib 3,3,3,2 with RS=0 (E high for 3 cycles each) -> four_bit_mode=1 after the 4th strobe, FSM in HIGH, proto_err=0.
- In 4-bit mode, send 0x01 then wait -> busy high exactly 32 cycles; rd_char=8'h20 for every rd_idx; ddram_addr=0.
- Send 0xC3, then data 'A' (0x41) -> rd_idx=19 reads 0x41; ddram_addr=0x44; byte_valid pulsed twice with byte_rs 0 then 1.
- Send entry 0x04, set addr 0x85, data 0x42, data 0x43 -> index 5=0x42, index 4=0x43, ddram_addr=0x03.
- E high for only 1 cycle, or a data byte during clear -> proto_err=1 and sticky; buffer unchanged.
- Assert nClear in the middle of a clear at cycle 10 -> busy=0, four_bit_mode=0, outputs 0; indices 0..9 = 0x20, others retain prior data.
